// File: rtl/uart_rx_param.sv
// UART receiver: 2-flop synchroniser, 3-sample majority bit decision and a show-ahead
// receive FIFO. Optional break detection is enabled by defining UART_RX_BREAK_DETECT_EN.
module uart_rx_param #(
   parameter int CLKS_PER_BIT = 20,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 uart_rxd,
   input  logic                 uart_rx_ready,
   output logic [DATA_BITS-1:0] uart_rx_data,
   output logic                 uart_valid,
   output logic                 uart_err,
   output logic                 uart_parity_err,
   output logic                 uart_overrun,
   output logic                 uart_break
);

   localparam int CW  = $clog2(CLKS_PER_BIT);
   localparam int MID = CLKS_PER_BIT / 2;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int EW  = DATA_BITS + 2;

   localparam logic [CW-1:0] SAMP_A    = CW'(MID - 1);
   localparam logic [CW-1:0] SAMP_B    = CW'(MID);
   localparam logic [CW-1:0] SAMP_C    = CW'(MID + 1);
   localparam logic [CW-1:0] LAST_CLK  = CW'(CLKS_PER_BIT - 1);
   localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
   localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   state_t state, state_n;

   logic                 sync1, sync2, rxd_s;
   logic [1:0]           live;
   logic                 armed;
   logic [CW-1:0]        clk_cnt;
   logic [3:0]           bit_cnt;
   logic [1:0]           samp;
   logic [DATA_BITS-1:0] shreg;
   logic                 pbit, ferr;
   logic                 mid, bit_end, maj, frame_done, push_req, perr_frame, brk_frame;
   logic [EW-1:0]        mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [AW:0]          count;
   logic                 pop, full, do_push;
   logic [EW-1:0]        head;

   assign rxd_s   = sync2;
   assign bit_end = (clk_cnt == LAST_CLK);
   assign mid     = (clk_cnt == SAMP_C);
   // third vote is the live sample on the decision cycle
   assign maj     = (samp[0] & samp[1]) | (samp[0] & rxd_s) | (samp[1] & rxd_s);

   assign perr_frame = (PARITY == 1) ? (^{shreg, pbit}) :
                       (PARITY == 2) ? ~(^{shreg, pbit}) : 1'b0;

   always_comb begin
      state_n    = state;
      frame_done = 1'b0;
      case (state)
         ST_IDLE:   if (armed && !rxd_s) state_n = ST_START;
         ST_START: begin
            if (mid && maj) state_n = ST_IDLE;
            else if (bit_end) state_n = ST_DATA;
         end
         ST_DATA:   if (bit_end && bit_cnt == LAST_DATA)
                       state_n = (PARITY != 0) ? ST_PARITY : ST_STOP;
         ST_PARITY: if (bit_end) state_n = ST_STOP;
         ST_STOP: begin
            if (mid && bit_cnt == LAST_STOP) begin
               state_n    = ST_IDLE;
               frame_done = 1'b1;
            end
         end
         default:   state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         sync1   <= 1'b1;
         sync2   <= 1'b1;
         live    <= 2'b00;
         armed   <= 1'b0;
         clk_cnt <= '0;
         bit_cnt <= '0;
         samp    <= '0;
         shreg   <= '0;
         pbit    <= 1'b0;
         ferr    <= 1'b0;
      end else begin
         state <= state_n;
         sync1 <= uart_rxd;
         sync2 <= sync1;
         live  <= {live[0], 1'b1};
         // the synchroniser reset value is not a line observation, so arming waits on live
         if (state_n != state) armed <= 1'b0;
         else if (state == ST_IDLE && rxd_s && live[1]) armed <= 1'b1;
         if (state == ST_IDLE) clk_cnt <= CW'(1);
         else if (bit_end) clk_cnt <= '0;
         else clk_cnt <= clk_cnt + 1'b1;
         if (clk_cnt == SAMP_A) samp[0] <= rxd_s;
         if (clk_cnt == SAMP_B) samp[1] <= rxd_s;
         if (state_n != state) bit_cnt <= '0;
         else if (bit_end) bit_cnt <= bit_cnt + 1'b1;
         if (state == ST_DATA && mid) shreg <= {maj, shreg[DATA_BITS-1:1]};
         if (state == ST_PARITY && mid) pbit <= maj;
         if (state == ST_START) ferr <= 1'b0;
         else if (state == ST_STOP && mid && !maj) ferr <= 1'b1;
      end
   end

`ifdef UART_RX_BREAK_DETECT_EN
   logic stop_low_first, break_flag, brk_now;

   assign brk_frame  = (shreg == '0) && !pbit && ((bit_cnt == 4'd0) ? !maj : stop_low_first);
   assign brk_now    = frame_done & brk_frame;
   assign uart_break = break_flag | brk_now;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stop_low_first <= 1'b0;
         break_flag     <= 1'b0;
      end else begin
         if (state == ST_STOP && mid && bit_cnt == 4'd0) stop_low_first <= ~maj;
         if (brk_now) break_flag <= 1'b1;
         else if (rxd_s) break_flag <= 1'b0;
      end
   end
`else
   assign brk_frame  = 1'b0;
   assign uart_break = 1'b0;
`endif

   assign push_req     = frame_done & ~brk_frame;
   assign pop          = uart_valid & uart_rx_ready;
   assign full         = (count == DEPTH_C);
   assign do_push      = push_req & (~full | pop);
   assign uart_overrun = push_req & full & ~pop;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= {perr_frame, ferr | ~maj, shreg};
   end

   assign head            = mem[rd_ptr];
   assign uart_valid      = (count != '0);
   assign uart_rx_data    = uart_valid ? head[DATA_BITS-1:0] : '0;
   assign uart_err        = uart_valid & head[DATA_BITS];
   assign uart_parity_err = uart_valid & head[DATA_BITS+1];

endmodule
